// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit for the RISC-V subset lh, sh, sub, or, andi, srl, beq.
// Sequences PC, IR, register file, ULA and the shared memory port; traps on bad opcodes and memory stalls.
module unidade_controle_multiciclo #(
    parameter int LARGURA_CONTADOR = 32,
    parameter int MAX_ESPERA       = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic [6:0]                  funct7,
    input  logic                        zero_ula,
    input  logic                        memoria_pronta,
    output logic                        escrever_pc,
    output logic                        selecao_pc,
    output logic                        escrever_ir,
    output logic                        selecao_endereco,
    output logic                        ler_memoria,
    output logic                        escrever_memoria,
    output logic [1:0]                  tamanho_memoria,
    output logic                        escrever_registrador,
    output logic                        selecao_escrita,
    output logic [1:0]                  selecao_ula_a,
    output logic [1:0]                  selecao_ula_b,
    output logic [3:0]                  operacao_ula,
    output logic [3:0]                  estado_atual,
    output logic                        instrucao_invalida,
    output logic                        erro_memoria,
    output logic [LARGURA_CONTADOR-1:0] contador_instrucoes
);
    // The wait counter only has to reach MAX_ESPERA-1; the next stalled cycle traps.
    localparam int LARGURA_ESPERA = (MAX_ESPERA > 1) ? $clog2(MAX_ESPERA) : 1;

    localparam logic [3:0] ULA_AND = 4'b0000;
    localparam logic [3:0] ULA_OR  = 4'b0001;
    localparam logic [3:0] ULA_ADD = 4'b0010;
    localparam logic [3:0] ULA_SUB = 4'b0110;
    localparam logic [3:0] ULA_SRL = 4'b1001;

    typedef enum logic [3:0] {
        BUSCA          = 4'd0,
        DECODIFICA     = 4'd1,
        EXECUTA_R      = 4'd2,
        EXECUTA_I      = 4'd3,
        CALC_ENDERECO  = 4'd4,
        ACESSO_LEITURA = 4'd5,
        ESCRITA_CARGA  = 4'd6,
        ACESSO_ESCRITA = 4'd7,
        ESCRITA_REG    = 4'd8,
        DESVIO         = 4'd9,
        ERRO           = 4'd15
    } estado_t;

    estado_t                     estado_reg, estado_next;
    logic [LARGURA_ESPERA-1:0]   espera_reg, espera_next;
    logic [LARGURA_CONTADOR-1:0] contador_reg, contador_next;
    logic                        invalida_reg, invalida_next;
    logic                        erro_mem_reg, erro_mem_next;
    logic [3:0]                  op_r_reg, op_r_next;
    logic                        eh_sh_reg, eh_sh_next;

    estado_t    destino_decod;
    logic [3:0] op_r_decod;
    logic       eh_sh_decod;
    logic       em_espera;
    logic       estouro;

    logic       escrever_pc_fsm, selecao_pc_fsm, escrever_ir_fsm, selecao_endereco_fsm;
    logic       ler_memoria_fsm, escrever_memoria_fsm, escrever_registrador_fsm, selecao_escrita_fsm;
    logic [1:0] tamanho_fsm, selecao_ula_a_fsm, selecao_ula_b_fsm;
    logic [3:0] operacao_fsm;

    always_comb begin
        destino_decod = ERRO;
        op_r_decod    = ULA_ADD;
        eh_sh_decod   = 1'b0;
        case (opcode)
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0100000_000: begin destino_decod = EXECUTA_R; op_r_decod = ULA_SUB; end
                    10'b0000000_110: begin destino_decod = EXECUTA_R; op_r_decod = ULA_OR;  end
                    10'b0000000_101: begin destino_decod = EXECUTA_R; op_r_decod = ULA_SRL; end
                    default:         destino_decod = ERRO;
                endcase
            end
            7'b0010011: if (funct3 == 3'b111) destino_decod = EXECUTA_I;
            7'b0000011: if (funct3 == 3'b001) destino_decod = CALC_ENDERECO;
            7'b0100011: begin
                if (funct3 == 3'b001) begin
                    destino_decod = CALC_ENDERECO;
                    eh_sh_decod   = 1'b1;
                end
            end
            7'b1100011: if (funct3 == 3'b000) destino_decod = DESVIO;
            default:    destino_decod = ERRO;
        endcase
    end

    assign em_espera = !memoria_pronta &&
                       (estado_reg == BUSCA || estado_reg == ACESSO_LEITURA || estado_reg == ACESSO_ESCRITA);
    assign estouro   = em_espera && (espera_reg == LARGURA_ESPERA'(MAX_ESPERA - 1));

    always_comb begin
        estado_next              = estado_reg;
        contador_next            = contador_reg;
        invalida_next            = invalida_reg;
        erro_mem_next            = erro_mem_reg;
        op_r_next                = op_r_reg;
        eh_sh_next               = eh_sh_reg;
        espera_next              = '0;
        escrever_pc_fsm          = 1'b0;
        selecao_pc_fsm           = 1'b0;
        escrever_ir_fsm          = 1'b0;
        selecao_endereco_fsm     = 1'b0;
        ler_memoria_fsm          = 1'b0;
        escrever_memoria_fsm     = 1'b0;
        escrever_registrador_fsm = 1'b0;
        selecao_escrita_fsm      = 1'b0;
        tamanho_fsm              = 2'b10;
        selecao_ula_a_fsm        = 2'b00;
        selecao_ula_b_fsm        = 2'b00;
        operacao_fsm             = ULA_ADD;

        case (estado_reg)
            BUSCA: begin
                ler_memoria_fsm   = 1'b1;
                selecao_ula_b_fsm = 2'b01;
                if (memoria_pronta) begin
                    escrever_ir_fsm = 1'b1;
                    escrever_pc_fsm = 1'b1;
                    estado_next     = DECODIFICA;
                end
            end
            DECODIFICA: begin
                // PC_antigo + imm lands in the ULA output register for a possible beq.
                selecao_ula_a_fsm = 2'b01;
                selecao_ula_b_fsm = 2'b10;
                estado_next       = destino_decod;
                op_r_next         = op_r_decod;
                eh_sh_next        = eh_sh_decod;
                if (destino_decod == ERRO) invalida_next = 1'b1;
            end
            EXECUTA_R: begin
                selecao_ula_a_fsm = 2'b10;
                operacao_fsm      = op_r_reg;
                estado_next       = ESCRITA_REG;
            end
            EXECUTA_I: begin
                selecao_ula_a_fsm = 2'b10;
                selecao_ula_b_fsm = 2'b10;
                operacao_fsm      = ULA_AND;
                estado_next       = ESCRITA_REG;
            end
            CALC_ENDERECO: begin
                selecao_ula_a_fsm = 2'b10;
                selecao_ula_b_fsm = 2'b10;
                estado_next       = eh_sh_reg ? ACESSO_ESCRITA : ACESSO_LEITURA;
            end
            ACESSO_LEITURA: begin
                selecao_endereco_fsm = 1'b1;
                ler_memoria_fsm      = 1'b1;
                tamanho_fsm          = 2'b01;
                if (memoria_pronta) estado_next = ESCRITA_CARGA;
            end
            ESCRITA_CARGA: begin
                escrever_registrador_fsm = 1'b1;
                selecao_escrita_fsm      = 1'b1;
                estado_next              = BUSCA;
                contador_next            = contador_reg + LARGURA_CONTADOR'(1);
            end
            ACESSO_ESCRITA: begin
                selecao_endereco_fsm = 1'b1;
                escrever_memoria_fsm = 1'b1;
                tamanho_fsm          = 2'b01;
                if (memoria_pronta) begin
                    estado_next   = BUSCA;
                    contador_next = contador_reg + LARGURA_CONTADOR'(1);
                end
            end
            ESCRITA_REG: begin
                escrever_registrador_fsm = 1'b1;
                estado_next              = BUSCA;
                contador_next            = contador_reg + LARGURA_CONTADOR'(1);
            end
            DESVIO: begin
                selecao_ula_a_fsm = 2'b10;
                operacao_fsm      = ULA_SUB;
                selecao_pc_fsm    = 1'b1;
                escrever_pc_fsm   = zero_ula;
                estado_next       = BUSCA;
                contador_next     = contador_reg + LARGURA_CONTADOR'(1);
            end
            ERRO: estado_next = ERRO;
            default: estado_next = ERRO;
        endcase

        if (em_espera) espera_next = espera_reg + LARGURA_ESPERA'(1);
        // A ready in the same cycle is handled above, so reaching here means a genuine stall.
        if (estouro) begin
            estado_next   = ERRO;
            erro_mem_next = 1'b1;
            espera_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_reg   <= BUSCA;
            espera_reg   <= '0;
            contador_reg <= '0;
            invalida_reg <= 1'b0;
            erro_mem_reg <= 1'b0;
            op_r_reg     <= ULA_ADD;
            eh_sh_reg    <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            espera_reg   <= espera_next;
            contador_reg <= contador_next;
            invalida_reg <= invalida_next;
            erro_mem_reg <= erro_mem_next;
            op_r_reg     <= op_r_next;
            eh_sh_reg    <= eh_sh_next;
        end
    end

    // Reset gates strobes and selects combinationally so an access is dropped without a clock.
    assign escrever_pc          = reset & escrever_pc_fsm;
    assign selecao_pc           = reset & selecao_pc_fsm;
    assign escrever_ir          = reset & escrever_ir_fsm;
    assign selecao_endereco     = reset & selecao_endereco_fsm;
    assign ler_memoria          = reset & ler_memoria_fsm;
    assign escrever_memoria     = reset & escrever_memoria_fsm;
    assign escrever_registrador = reset & escrever_registrador_fsm;
    assign selecao_escrita      = reset & selecao_escrita_fsm;
    assign selecao_ula_a        = reset ? selecao_ula_a_fsm : 2'b00;
    assign selecao_ula_b        = reset ? selecao_ula_b_fsm : 2'b00;
    assign tamanho_memoria      = tamanho_fsm;
    assign operacao_ula         = operacao_fsm;
    assign estado_atual         = estado_reg;
    assign instrucao_invalida   = invalida_reg;
    assign erro_memoria         = erro_mem_reg;
    assign contador_instrucoes  = contador_reg;
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench: the driver walks each instruction through its phase list and queues expected outputs;
// a negedge monitor pops one record per cycle and compares against the DUT.
module tb_unidade_controle_multiciclo;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero_ula;
    logic        memoria_pronta;
    logic        escrever_pc, selecao_pc, escrever_ir, selecao_endereco;
    logic        ler_memoria, escrever_memoria, escrever_registrador, selecao_escrita;
    logic [1:0]  tamanho_memoria, selecao_ula_a, selecao_ula_b;
    logic [3:0]  operacao_ula, estado_atual;
    logic        instrucao_invalida, erro_memoria;
    logic [31:0] contador_instrucoes;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.LARGURA_CONTADOR(32), .MAX_ESPERA(MAXW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_ula(zero_ula), .memoria_pronta(memoria_pronta),
        .escrever_pc(escrever_pc), .selecao_pc(selecao_pc), .escrever_ir(escrever_ir),
        .selecao_endereco(selecao_endereco), .ler_memoria(ler_memoria),
        .escrever_memoria(escrever_memoria), .tamanho_memoria(tamanho_memoria),
        .escrever_registrador(escrever_registrador), .selecao_escrita(selecao_escrita),
        .selecao_ula_a(selecao_ula_a), .selecao_ula_b(selecao_ula_b),
        .operacao_ula(operacao_ula), .estado_atual(estado_atual),
        .instrucao_invalida(instrucao_invalida), .erro_memoria(erro_memoria),
        .contador_instrucoes(contador_instrucoes)
    );

    typedef struct packed {
        logic [3:0]  estado;
        logic        esc_pc, sel_pc, esc_ir, sel_end, ler, esc_mem;
        logic [1:0]  tam;
        logic        esc_reg, sel_esc;
        logic [1:0]  ua, ub;
        logic [3:0]  op;
        logic        inval, errm;
        logic [31:0] cnt;
    } obs_t;

    typedef enum int {K_SUB, K_OR, K_SRL, K_ANDI, K_LH, K_SH, K_BEQ, K_INV, K_INV2} kind_t;

    obs_t        exp_q[$];
    string       lbl_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_cnt = 0;
    bit          m_inval = 0;
    bit          m_errm = 0;

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop_of(kind_t k);
        case (k)
            K_SUB:   return 4'b0110;
            K_OR:    return 4'b0001;
            K_SRL:   return 4'b1001;
            default: return 4'b0010;
        endcase
    endfunction

    // Output table of each phase as the specification lists it.
    function automatic obs_t model_out(int st, bit pronta, bit zero, logic [3:0] rop);
        obs_t o;
        o = '0;
        o.estado = 4'(st); o.tam = 2'b10; o.op = 4'b0010;
        o.inval = m_inval; o.errm = m_errm; o.cnt = m_cnt;
        case (st)
            0:  begin o.ler = 1; o.ub = 2'b01; o.esc_ir = pronta; o.esc_pc = pronta; end
            1:  begin o.ua = 2'b01; o.ub = 2'b10; end
            2:  begin o.ua = 2'b10; o.op = rop; end
            3:  begin o.ua = 2'b10; o.ub = 2'b10; o.op = 4'b0000; end
            4:  begin o.ua = 2'b10; o.ub = 2'b10; end
            5:  begin o.sel_end = 1; o.ler = 1; o.tam = 2'b01; end
            6:  begin o.esc_reg = 1; o.sel_esc = 1; end
            7:  begin o.sel_end = 1; o.esc_mem = 1; o.tam = 2'b01; end
            8:  o.esc_reg = 1;
            9:  begin o.ua = 2'b10; o.op = 4'b0110; o.sel_pc = 1; o.esc_pc = zero; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input obs_t o, input string lbl);
        exp_q.push_back(o);
        lbl_q.push_back(lbl);
        @(posedge clk); #1;
    endtask

    task automatic step(input int st, input bit pronta, input bit zero, input logic [3:0] rop,
                        input bit retire, input string lbl);
        memoria_pronta = pronta;
        zero_ula       = zero;
        push(model_out(st, pronta, zero, rop), lbl);
        if (retire) m_cnt = m_cnt + 1;
    endtask

    task automatic mem_phase(input int st, input int waits, input bit retire, input string lbl);
        for (int i = 0; i < waits; i++) step(st, 1'b0, rbit(), 4'b0010, 1'b0, lbl);
        step(st, 1'b1, rbit(), 4'b0010, retire, lbl);
    endtask

    task automatic stall_to_error(input int st, input string lbl);
        for (int i = 0; i < MAXW; i++) step(st, 1'b0, rbit(), 4'b0010, 1'b0, lbl);
        m_errm = 1;
        repeat (5) step(15, rbit(), rbit(), 4'b0010, 1'b0, lbl);
    endtask

    task automatic do_reset(input int n, input string lbl);
        obs_t o;
        reset = 1'b0;
        m_cnt = 0; m_inval = 0; m_errm = 0;
        o = '0; o.tam = 2'b10; o.op = 4'b0010;
        for (int i = 0; i < n; i++) begin
            memoria_pronta = rbit();
            zero_ula       = rbit();
            push(o, lbl);
        end
        reset = 1'b1;
    endtask

    task automatic set_ir(input kind_t k);
        funct7 = 7'($urandom);
        funct3 = 3'($urandom);
        case (k)
            K_SUB:  begin opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; end
            K_OR:   begin opcode = 7'b0110011; funct3 = 3'b110; funct7 = 7'b0000000; end
            K_SRL:  begin opcode = 7'b0110011; funct3 = 3'b101; funct7 = 7'b0000000; end
            K_ANDI: begin opcode = 7'b0010011; funct3 = 3'b111; end
            K_LH:   begin opcode = 7'b0000011; funct3 = 3'b001; end
            K_SH:   begin opcode = 7'b0100011; funct3 = 3'b001; end
            K_BEQ:  begin opcode = 7'b1100011; funct3 = 3'b000; end
            K_INV:  opcode = 7'b1101111;
            default: begin opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; end
        endcase
    endtask

    // Fetch with garbage on the IR bits (they must be ignored), then load the real instruction.
    task automatic fetch_decode(input kind_t k, input int w0, input string lbl);
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        mem_phase(0, w0, 1'b0, lbl);
        set_ir(k);
        step(1, rbit(), rbit(), 4'b0010, 1'b0, lbl);
    endtask

    task automatic run_instr(input kind_t k, input int w0, input int w1, input bit z, input string lbl);
        logic [3:0] r;
        r = rop_of(k);
        fetch_decode(k, w0, lbl);
        case (k)
            K_SUB, K_OR, K_SRL: begin
                step(2, rbit(), rbit(), r, 1'b0, lbl);
                step(8, rbit(), rbit(), r, 1'b1, lbl);
            end
            K_ANDI: begin
                step(3, rbit(), rbit(), r, 1'b0, lbl);
                step(8, rbit(), rbit(), r, 1'b1, lbl);
            end
            K_LH: begin
                step(4, rbit(), rbit(), r, 1'b0, lbl);
                mem_phase(5, w1, 1'b0, lbl);
                step(6, rbit(), rbit(), r, 1'b1, lbl);
            end
            K_SH: begin
                step(4, rbit(), rbit(), r, 1'b0, lbl);
                mem_phase(7, w1, 1'b1, lbl);
            end
            K_BEQ: step(9, rbit(), z, r, 1'b1, lbl);
            default: begin
                m_inval = 1;
                repeat (20) step(15, rbit(), rbit(), r, 1'b0, lbl);
            end
        endcase
        $display("[TB] %s kind=%0d w0=%0d w1=%0d z=%0d cnt=%0d", lbl, k, w0, w1, z, m_cnt);
    endtask

    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string l;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            a.estado = estado_atual;     a.esc_pc = escrever_pc;    a.sel_pc = selecao_pc;
            a.esc_ir = escrever_ir;      a.sel_end = selecao_endereco;
            a.ler = ler_memoria;         a.esc_mem = escrever_memoria;
            a.tam = tamanho_memoria;     a.esc_reg = escrever_registrador;
            a.sel_esc = selecao_escrita; a.ua = selecao_ula_a;      a.ub = selecao_ula_b;
            a.op = operacao_ula;         a.inval = instrucao_invalida;
            a.errm = erro_memoria;       a.cnt = contador_instrucoes;
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: state got=%0d req=%0d, outputs got=%h required=%h",
                         l, a.estado, e.estado, a, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        kind_t k;
        reset = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; zero_ula = 0; memoria_pronta = 0;
        @(posedge clk); #1;
        do_reset(3, "reset_init");

        run_instr(K_SUB, 0, 0, 0, "sub_basic");
        run_instr(K_LH, 0, 3, 0, "lh_wait3");
        run_instr(K_BEQ, 0, 0, 1, "beq_taken");
        run_instr(K_BEQ, 0, 0, 0, "beq_not_taken");
        run_instr(K_OR, MAXW - 1, 0, 0, "ready_on_last_wait");
        run_instr(K_SH, 0, MAXW - 1, 0, "sh_wait_limit");

        for (int i = 0; i < 200; i++) begin
            k = kind_t'($urandom_range(0, 6));
            run_instr(k, $urandom_range(0, MAXW - 1), $urandom_range(0, MAXW - 1), rbit(), "random");
        end

        run_instr(K_INV, 0, 0, 0, "invalid_jal");
        do_reset(2, "reset_after_invalid");
        run_instr(K_INV2, 1, 0, 0, "invalid_add");
        do_reset(1, "reset_after_invalid2");

        run_instr(K_ANDI, 0, 0, 0, "andi_before_timeout");
        opcode = 7'($urandom);
        stall_to_error(0, "timeout_busca");
        do_reset(2, "reset_after_timeout");

        fetch_decode(K_SH, 0, "timeout_escrita");
        step(4, rbit(), rbit(), 4'b0010, 1'b0, "timeout_escrita");
        stall_to_error(7, "timeout_escrita");
        do_reset(1, "reset_after_timeout2");

        run_instr(K_SRL, 0, 0, 0, "srl_before_abort");
        fetch_decode(K_SH, 0, "abort_sh");
        step(4, rbit(), rbit(), 4'b0010, 1'b0, "abort_sh");
        step(7, 1'b0, rbit(), 4'b0010, 1'b0, "abort_sh");
        memoria_pronta = 1'b0;
        do_reset(2, "reset_mid_store");
        run_instr(K_SUB, 0, 0, 0, "sub_after_abort");

        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d records left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Multi-cycle control FSM that sequences the RISC-V datapath (PC, IR, register file, ULA, shared instruction/data memory) for the subset lh, sh, sub, or, andi, srl, beq.
- Emits per-state mux selects and write strobes, and handles a ready handshake with the single memory port.
- Adds a memory-wait timeout, invalid-instruction trap and a retired-instruction counter.

Parameters:
- LARGURA_CONTADOR, 32: width of contador_instrucoes.
- MAX_ESPERA, 15: consecutive not-ready cycles allowed in one memory state before trapping.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- zero_ula  in  1  ULA zero flag.
- memoria_pronta  in  1  memory completes the current access this cycle.
- escrever_pc  out  1  PC load strobe.
- selecao_pc  out  1  PC source: 0 = ULA output, 1 = ULA output register.
- escrever_ir  out  1  loads IR and PC_antigo.
- selecao_endereco  out  1  memory address source: 0 = PC, 1 = ULA output register.
- ler_memoria  out  1  read request.
- escrever_memoria  out  1  write request.
- tamanho_memoria  out  2  access size: 01 = half, 10 = word.
- escrever_registrador  out  1  register-file write strobe.
- selecao_escrita  out  1  write-back source: 0 = ULA output register, 1 = memory data register.
- selecao_ula_a  out  2  ULA A input: 00 = PC, 01 = PC_antigo, 10 = rs1.
- selecao_ula_b  out  2  ULA B input: 00 = rs2, 01 = constant 4, 10 = immediate.
- operacao_ula  out  4  ULA operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 SRL.
- estado_atual  out  4  current state encoding.
- instrucao_invalida  out  1  sticky invalid-instruction flag.
- erro_memoria  out  1  sticky memory-timeout flag.
- contador_instrucoes  out  LARGURA_CONTADOR  retired instructions, wraps at 2^LARGURA_CONTADOR.

Behaviour:
- Reset:
  - reset low → state BUSCA, contador_instrucoes = 0, wait counter = 0, both error flags = 0.
  - While reset is low, every strobe (escrever_*, ler_memoria) is 0 and every select is 0.
  - Asserting reset mid-access drops all strobes immediately.
- Outputs are Moore per state, except strobes gated by memoria_pronta or zero_ula (Mealy). Unlisted outputs are 0.
- Default outputs: operacao_ula = ADD, tamanho_memoria = 10.
- Opcode/funct inputs are sampled only from DECODIFICA onward; IR is stable after BUSCA.
- BUSCA (0):
  - Outputs: selecao_endereco=0, ler_memoria=1, ula_a=00, ula_b=01.
  - On memoria_pronta: escrever_ir=1, escrever_pc=1, selecao_pc=0, next DECODIFICA. Otherwise stay.
- DECODIFICA (1):
  - Outputs: ula_a=01, ula_b=10, ADD; the branch target is latched into the ULA output register.
  - Decode and next state:
    - 0110011 with {funct7, funct3} = {0100000,000} sub / {0000000,110} or / {0000000,101} srl → EXECUTA_R.
    - 0010011 with funct3 111 (andi) → EXECUTA_I.
    - 0000011 with funct3 001 (lh), or 0100011 with funct3 001 (sh) → CALC_ENDERECO.
    - 1100011 with funct3 000 (beq) → DESVIO.
    - Anything else → ERRO with instrucao_invalida=1.
- EXECUTA_R (2): ula_a=10, ula_b=00, op = SUB/OR/SRL per decode. Next ESCRITA_REG.
- EXECUTA_I (3): ula_a=10, ula_b=10, op AND. Next ESCRITA_REG.
- CALC_ENDERECO (4): ula_a=10, ula_b=10, ADD. Next ACESSO_LEITURA for lh, ACESSO_ESCRITA for sh.
- ACESSO_LEITURA (5): selecao_endereco=1, ler_memoria=1, tamanho=01. On memoria_pronta → ESCRITA_CARGA.
- ESCRITA_CARGA (6): escrever_registrador=1, selecao_escrita=1. Next BUSCA; counter +1.
- ACESSO_ESCRITA (7): selecao_endereco=1, escrever_memoria=1, tamanho=01. On memoria_pronta → BUSCA; counter +1.
- ESCRITA_REG (8): escrever_registrador=1, selecao_escrita=0. Next BUSCA; counter +1.
- DESVIO (9): ula_a=10, ula_b=00, SUB, selecao_pc=1, escrever_pc = zero_ula. Next BUSCA; counter +1.
- ERRO (15): all strobes 0; absorbing until reset.
- Memory-wait timeout:
  - The wait counter increments each not-ready cycle in states 0, 5 and 7, and clears on state exit.
  - When the MAX_ESPERA-th consecutive not-ready cycle occurs → ERRO, erro_memoria=1.
  - memoria_pronta in that same cycle wins: normal transition, no error.
- Latency with memoria_pronta=1 every cycle: R/I = 4 cycles, beq = 3, sh = 4, lh = 5.
- Each extra wait cycle adds 1 to the latency.

Test Plan:
1. Release reset, memoria_pronta=1, IR=sub (0110011/000/0100000) → estado_atual 0,1,2,8,0; operacao_ula=0110 in state 2; escrever_registrador=1 only in state 8; contador_instrucoes=1.
2. lh with memoria_pronta low for 3 cycles in state 5 → ler_memoria=1 and tamanho=01 held for 4 cycles; then state 6 with selecao_escrita=1; total 8 cycles; no error.
3. beq with zero_ula=1, then beq with zero_ula=0 → state 9: escrever_pc=1, selecao_pc=1 vs escrever_pc=0; both return to 0; counter +2.
4. opcode 1101111 → state 15, instrucao_invalida=1, all strobes 0 for 20 cycles; reset low → state 0, flag cleared.
5. MAX_ESPERA=4, memoria_pronta held 0 in BUSCA → state 15 after 4 cycles, erro_memoria=1. Separate run: ready on the 4th cycle → DECODIFICA, no error.
6. reset pulled low mid ACESSO_ESCRITA → escrever_memoria=0 without waiting for clk; state 0, contador_instrucoes=0.
